// File: rtl/booth_r4_mult_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: FSM state codes and
// recode select constants.
package booth_r4_mult_pkg;

  // FSM state encodings
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  // Magnitude selects produced by the recoder
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_1X   = 2'b01;
  localparam logic [1:0] SEL_2X   = 2'b10;

  // Recode results as {negate, select}
  localparam logic [2:0] BR_ZERO = {1'b0, SEL_ZERO};
  localparam logic [2:0] BR_P1   = {1'b0, SEL_1X};
  localparam logic [2:0] BR_P2   = {1'b0, SEL_2X};
  localparam logic [2:0] BR_N1   = {1'b1, SEL_1X};
  localparam logic [2:0] BR_N2   = {1'b1, SEL_2X};

endpackage

// File: rtl/booth_r4_mult_if.sv
// Start/done handshake and operand/result bus of the Booth multiplier.
interface booth_r4_mult_if #(
  parameter int W = 8
);
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, p
  );
endinterface

// File: rtl/booth_r4_mult_recode.sv
// Radix-4 Booth recoder: maps a multiplier bit triplet to a magnitude
// select (0, 1x, 2x) and a negate flag.
module booth_r4_recode (
  input  logic [2:0] i_trip,
  output logic [1:0] o_sel,
  output logic       o_neg
);
  import booth_r4_mult_pkg::*;

  logic [2:0] w_code;

  // Triplet {q[1], q[0], q_m1} to signed digit in {-2,-1,0,+1,+2}
  always_comb begin
    w_code = BR_ZERO;
    unique case (i_trip)
      3'b000, 3'b111: w_code = BR_ZERO;
      3'b001, 3'b010: w_code = BR_P1;
      3'b011:         w_code = BR_P2;
      3'b100:         w_code = BR_N2;
      3'b101, 3'b110: w_code = BR_N1;
      default:        w_code = BR_ZERO;
    endcase
  end

  assign o_sel = w_code[1:0];
  assign o_neg = w_code[2];

endmodule

// File: rtl/booth_r4_mult.sv
// Radix-4 Booth sequential multiplier, signed or unsigned operands selected
// per operation. Retires two multiplier bits per CALC cycle over W/2+1 steps.
module booth_r4_mult #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  booth_r4_mult_if.slave bus
);
  import booth_r4_mult_pkg::*;

  localparam int K  = W / 2 + 1;        // Booth steps per operation
  localparam int CW = $clog2(K + 1);    // counter width
  localparam int QW = W + 2;            // extended operand width
  localparam int AW = W + 4;            // accumulator width, holds +/-2M
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  logic [0:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic [AW-1:0]  r_acc;
  logic [QW-1:0]  r_q;
  logic           r_qm1;
  logic [QW-1:0]  r_m;
  logic [2*W-1:0] r_p;
  logic           r_done;

  logic [1:0]        w_sel;
  logic              w_neg;
  logic [AW-1:0]     w_mag;
  logic [AW-1:0]     w_addend;
  logic [AW-1:0]     w_sum;
  logic [AW+QW:0]    w_shift;
  logic              w_ext_a;
  logic              w_ext_b;

  booth_r4_recode u_recode (
    .i_trip ({r_q[1:0], r_qm1}),
    .o_sel  (w_sel),
    .o_neg  (w_neg)
  );

  // Sign bits used to extend operands to W+2 bits; zero in unsigned mode
  assign w_ext_a = bus.signed_mode & bus.a[W-1];
  assign w_ext_b = bus.signed_mode & bus.b[W-1];

  // Selected multiple of M, sign-extended to accumulator width
  always_comb begin
    w_mag = '0;
    unique case (w_sel)
      SEL_1X:  w_mag = {{2{r_m[QW-1]}}, r_m};
      SEL_2X:  w_mag = {r_m[QW-1], r_m, 1'b0};
      default: w_mag = '0;
    endcase
  end

  // Negation as one's complement plus carry-in; the whole
  // {acc, q, q_m1} string then shifts right arithmetically by two.
  assign w_addend = w_neg ? ~w_mag : w_mag;
  assign w_sum    = r_acc + w_addend + AW'(w_neg);
  assign w_shift  = $signed({w_sum, r_q, r_qm1}) >>> 2;

  // Control FSM and datapath registers; p loads from the final step directly
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_m     <= '0;
      r_p     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_m     <= {{2{w_ext_a}}, bus.a};
            r_q     <= {{2{w_ext_b}}, bus.b};
            r_qm1   <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_acc <= w_shift[AW+QW:QW+1];
          r_q   <= w_shift[QW:1];
          r_qm1 <= w_shift[0];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_p     <= w_shift[2*W:1];
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == CALC);
  assign bus.done = r_done;
  assign bus.p    = r_p;

endmodule

// File: tb/tb_booth_r4_mult.sv
// Directed, table-driven bench for booth_r4_mult at W=8 and W=4.
module tb_booth_r4_mult;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  booth_r4_mult_if #(.W(8)) bus8 ();
  booth_r4_mult_if #(.W(4)) bus4 ();

  booth_r4_mult #(.W(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
  booth_r4_mult #(.W(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

  typedef struct {
    bit          w4;
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_p;
    int          exp_lat;
  } vec_t;

  vec_t vecs[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic cur_done(input bit w4);
    return w4 ? bus4.done : bus8.done;
  endfunction

  function automatic logic cur_busy(input bit w4);
    return w4 ? bus4.busy : bus8.busy;
  endfunction

  function automatic logic [15:0] cur_p(input bit w4);
    return w4 ? {8'h00, bus4.p} : bus8.p;
  endfunction

  // One start pulse, then wait (bounded) for done
  task automatic op(input bit w4, input logic sm, input logic [7:0] a, input logic [7:0] b,
                    output logic [15:0] p, output int lat, output int bcnt, output bit held);
    logic [15:0] p0;
    p0 = cur_p(w4);
    if (w4) begin
      bus4.signed_mode = sm; bus4.a = a[3:0]; bus4.b = b[3:0]; bus4.start = 1'b1;
    end else begin
      bus8.signed_mode = sm; bus8.a = a; bus8.b = b; bus8.start = 1'b1;
    end
    step();
    bus4.start = 1'b0;
    bus8.start = 1'b0;
    lat  = 0;
    held = 1'b1;
    bcnt = int'(cur_busy(w4));
    while (!cur_done(w4) && lat < 20) begin
      if (cur_p(w4) !== p0) held = 1'b0;
      step();
      lat++;
      bcnt += int'(cur_busy(w4));
    end
    p = cur_p(w4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p;
    int lat, bcnt, ndone;
    bit held;

    vecs[0]  = '{0, 1'b0, 8'd10,  8'd1,   16'h000A, 5};
    vecs[1]  = '{0, 1'b1, 8'hFD,  8'h05,  16'hFFF1, 5};
    vecs[2]  = '{0, 1'b1, 8'h80,  8'h80,  16'h4000, 5};
    vecs[3]  = '{0, 1'b0, 8'hFF,  8'hFF,  16'hFE01, 5};
    vecs[4]  = '{0, 1'b1, 8'hFF,  8'hFF,  16'h0001, 5};
    vecs[5]  = '{0, 1'b0, 8'd7,   8'd6,   16'h002A, 5};
    vecs[6]  = '{0, 1'b0, 8'h80,  8'h80,  16'h4000, 5};
    vecs[7]  = '{0, 1'b1, 8'h7F,  8'h80,  16'hC080, 5};
    vecs[8]  = '{0, 1'b1, 8'h80,  8'h7F,  16'hC080, 5};
    vecs[9]  = '{0, 1'b0, 8'hFF,  8'h00,  16'h0000, 5};
    vecs[10] = '{0, 1'b0, 8'hC8,  8'h03,  16'h0258, 5};
    vecs[11] = '{0, 1'b1, 8'hC8,  8'h03,  16'hFF58, 5};
    vecs[12] = '{1, 1'b0, 8'h0F,  8'h0F,  16'h00E1, 3};
    vecs[13] = '{1, 1'b1, 8'h08,  8'h07,  16'h00C8, 3};
    vecs[14] = '{1, 1'b0, 8'h08,  8'h08,  16'h0040, 3};
    vecs[15] = '{1, 1'b1, 8'h0F,  8'h0F,  16'h0001, 3};
    vecs[16] = '{1, 1'b1, 8'h08,  8'h08,  16'h0040, 3};

    bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.a = '0; bus8.b = '0;
    bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.a = '0; bus4.b = '0;

    // Reset state
    step(); step();
    chk("reset busy8", 32'(bus8.busy), 32'd0);
    chk("reset done8", 32'(bus8.done), 32'd0);
    chk("reset p8",    32'(bus8.p),    32'd0);
    chk("reset busy4", 32'(bus4.busy), 32'd0);
    chk("reset p4",    32'(bus4.p),    32'd0);
    reset = 1'b0;
    step();

    // Table of single operations
    for (int i = 0; i < 17; i++) begin
      op(vecs[i].w4, vecs[i].sm, vecs[i].a, vecs[i].b, p, lat, bcnt, held);
      chk($sformatf("vec%0d p", i),       32'(p),    32'(vecs[i].exp_p));
      chk($sformatf("vec%0d latency", i), lat,       vecs[i].exp_lat);
      chk($sformatf("vec%0d busy cycles", i), bcnt,  vecs[i].exp_lat);
      chk($sformatf("vec%0d p held in calc", i), 32'(held), 32'd1);
      chk($sformatf("vec%0d busy at done", i), 32'(cur_busy(vecs[i].w4)), 32'd0);
      step();
      chk($sformatf("vec%0d done one cycle", i), 32'(cur_done(vecs[i].w4)), 32'd0);
      chk($sformatf("vec%0d p hold after", i), 32'(cur_p(vecs[i].w4)), 32'(vecs[i].exp_p));
    end

    // Start held high: 7*6, 9*9, 0*255 back to back; operand changes and
    // a start toggle while busy must not matter
    bus8.signed_mode = 1'b0; bus8.a = 8'd7; bus8.b = 8'd6; bus8.start = 1'b1;
    step();
    ndone = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc == 0) begin bus8.a = 8'd9; bus8.b = 8'd9; end
      if (cyc == 7) bus8.start = 1'b0;
      if (cyc == 8) begin bus8.start = 1'b1; bus8.a = 8'd0; bus8.b = 8'd255; end
      if (cyc == 12) bus8.start = 1'b0;
      chk($sformatf("b2b done cyc%0d", cyc), 32'(bus8.done),
          32'((cyc == 5) || (cyc == 11) || (cyc == 17)));
      if (bus8.done) ndone++;
      if (cyc == 5)  chk("b2b p 7*6", 32'(bus8.p), 32'd42);
      if (cyc == 11) chk("b2b p 9*9", 32'(bus8.p), 32'd81);
      if (cyc == 17) chk("b2b p 0*255", 32'(bus8.p), 32'd0);
      step();
    end
    chk("b2b done count", ndone, 3);

    // Give p a nonzero value, then reset two cycles into 7*6
    op(1'b0, 1'b0, 8'd5, 8'd5, p, lat, bcnt, held);
    chk("pre-abort p", 32'(p), 32'd25);
    step();
    bus8.a = 8'd7; bus8.b = 8'd6; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    step(); step();
    chk("abort busy before reset", 32'(bus8.busy), 32'd1);
    reset = 1'b1;
    step();
    chk("abort busy", 32'(bus8.busy), 32'd0);
    chk("abort done", 32'(bus8.done), 32'd0);
    chk("abort p",    32'(bus8.p),    32'd0);
    reset = 1'b0;
    ndone = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step();
      if (bus8.done) ndone++;
    end
    chk("abort no done", ndone, 0);
    op(1'b0, 1'b0, 8'd7, 8'd6, p, lat, bcnt, held);
    chk("after abort p", 32'(p), 32'd42);
    chk("after abort latency", lat, 5);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
